// File: rtl/mxu_pkg.sv
// Shared types and constants for the MXU phase sequencer and its register wrapper.
package mxu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MULT = 3'd2,
        ACC  = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    // Status byte the wrapper writes into cache[0] once a run completes.
    localparam logic [7:0] DONE_STATUS  = 8'h02;
    localparam int         SIZE_DEFAULT = 16;

    // Operand load: one row per cycle.
    function automatic int load_cycles(input int size);
        return size;
    endfunction

    // Systolic wavefront needs 3*SIZE-2 cycles to fully cross the array.
    function automatic int mult_cycles(input int size);
        return 3 * size - 2;
    endfunction

    // Accumulator drain: one row per cycle.
    function automatic int acc_cycles(input int size);
        return size;
    endfunction

endpackage

// File: rtl/mxu_phase_counter.sv
// Up-counter with synchronous clear and terminal-count compare; restarted at every phase change.
module mxu_phase_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] term,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    // Clear dominates increment so a phase change always restarts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/mxu_sequencer.sv
// LOAD -> MULT -> ACC phase sequencer for the SIZE x SIZE systolic array.
module mxu_sequencer
    import mxu_pkg::*;
#(
    parameter  int SIZE = SIZE_DEFAULT,
    localparam int CW   = $clog2(3 * SIZE),
    localparam int RW   = $clog2(SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          clear,
    output logic          load_en,
    output logic          mult_en,
    output logic          acc_en,
    output logic [RW-1:0] row_idx,
    output logic [CW-1:0] step_cnt,
    output logic          busy,
    output logic          done,
    output logic          start_err
);

    localparam logic [CW-1:0] LOAD_LAST = CW'(load_cycles(SIZE) - 1);
    localparam logic [CW-1:0] MULT_LAST = CW'(mult_cycles(SIZE) - 1);
    localparam logic [CW-1:0] ACC_LAST  = CW'(acc_cycles(SIZE) - 1);

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] term;
    logic          tc;
    logic          in_run;
    logic          cnt_clr;

    assign in_run  = (state_q == LOAD) || (state_q == MULT) || (state_q == ACC);
    // Counter only runs inside a phase; it is zeroed on every state change so it never wraps.
    assign cnt_clr = (state_d != state_q) || !in_run;

    mxu_phase_counter #(.CW(CW)) u_cnt (
        .clk  (clk),
        .rst  (reset),
        .clr  (cnt_clr),
        .en   (in_run),
        .term (term),
        .cnt  (cnt),
        .tc   (tc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // A start that lands mid-run is dropped but flagged for exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            start_err <= 1'b0;
        else
            start_err <= start && in_run;
    end

    // Next-state logic; clear beats a same-cycle phase transition, start beats clear in DONE.
    always_comb begin
        state_d = state_q;
        term    = '0;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                term = LOAD_LAST;
                if (clear)   state_d = IDLE;
                else if (tc) state_d = MULT;
            end
            MULT: begin
                term = MULT_LAST;
                if (clear)   state_d = IDLE;
                else if (tc) state_d = ACC;
            end
            ACC: begin
                term = ACC_LAST;
                if (clear)   state_d = IDLE;
                else if (tc) state_d = DONE;
            end
            DONE: begin
                if (start)      state_d = LOAD;
                else if (clear) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the registered state and counter; enables are one-hot by construction.
    always_comb begin
        load_en  = 1'b0;
        mult_en  = 1'b0;
        acc_en   = 1'b0;
        done     = 1'b0;
        row_idx  = '0;
        busy     = in_run;
        step_cnt = cnt;
        case (state_q)
            LOAD: begin
                load_en = 1'b1;
                row_idx = cnt[RW-1:0];
            end
            MULT: mult_en = 1'b1;
            ACC: begin
                acc_en  = 1'b1;
                row_idx = cnt[RW-1:0];
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mxu_sequencer.sv
// Directed bench for mxu_sequencer: SIZE=4 schedule details plus a SIZE=16 length check.
module tb_mxu_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start4 = 1'b0, clear4 = 1'b0;
    logic start16 = 1'b0, clear16 = 1'b0;

    logic       load_en4, mult_en4, acc_en4, busy4, done4, start_err4;
    logic [1:0] row_idx4;
    logic [3:0] step_cnt4;

    logic       load_en16, mult_en16, acc_en16, busy16, done16, start_err16;
    logic [3:0] row_idx16;
    logic [5:0] step_cnt16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mxu_sequencer #(.SIZE(4)) dut4 (
        .clk(clk), .reset(rst), .start(start4), .clear(clear4),
        .load_en(load_en4), .mult_en(mult_en4), .acc_en(acc_en4),
        .row_idx(row_idx4), .step_cnt(step_cnt4), .busy(busy4),
        .done(done4), .start_err(start_err4)
    );

    mxu_sequencer #(.SIZE(16)) dut16 (
        .clk(clk), .reset(rst), .start(start16), .clear(clear16),
        .load_en(load_en16), .mult_en(mult_en16), .acc_en(acc_en16),
        .row_idx(row_idx16), .step_cnt(step_cnt16), .busy(busy16),
        .done(done16), .start_err(start_err16)
    );

    // {start_err, load, mult, acc, busy, done, row[1:0], step[3:0]}
    logic [11:0] obs4;
    assign obs4 = {start_err4, load_en4, mult_en4, acc_en4, busy4, done4, row_idx4, step_cnt4};

    // Hand-derived SIZE=4 schedule, rel = cycles since the edge that sampled start.
    function automatic logic [11:0] exp4(input int rel);
        logic l, m, a, b, d;
        logic [1:0] r;
        logic [3:0] s;
        l = 0; m = 0; a = 0; b = 0; d = 0; r = '0; s = '0;
        if (rel >= 1 && rel <= 4) begin
            l = 1; b = 1; r = 2'(rel - 1); s = 4'(rel - 1);
        end else if (rel >= 5 && rel <= 14) begin
            m = 1; b = 1; s = 4'(rel - 5);
        end else if (rel >= 15 && rel <= 18) begin
            a = 1; b = 1; r = 2'(rel - 15); s = 4'(rel - 15);
        end else if (rel >= 19) begin
            d = 1;
        end
        return {1'b0, l, m, a, b, d, r, s};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({obs4, load_en16, mult_en16, acc_en16, busy16, done16, start_err16, row_idx16, step_cnt16} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got %h / %b want all zero", obs4,
                     {load_en16, mult_en16, acc_en16, busy16, done16, start_err16, row_idx16, step_cnt16});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs4 !== 12'h000) begin
            errors++;
            $display("FAIL reset_release: got %h want 000", obs4);
        end
    endtask

    task automatic clear_to_idle4();
        clear4 = 1'b1;
        @(negedge clk);
        clear4 = 1'b0;
        checks++;
        if (obs4 !== 12'h000) begin
            errors++;
            $display("FAIL clear_ack: got %h want 000", obs4);
        end
    endtask

    task automatic test_schedule4();
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) begin
                checks++;
                if (obs4 !== exp4(c)) begin
                    errors++;
                    $display("FAIL sched4 cycle %0d: got %h want %h", c, obs4, exp4(c));
                end
            end
            start4 = (c == 0);
            @(negedge clk);
        end
        start4 = 1'b0;
        clear_to_idle4();
    endtask

    task automatic test_start_err();
        logic [11:0] e;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) begin
                e = exp4(c);
                if (c == 8) e[11] = 1'b1;
                checks++;
                if (obs4 !== e) begin
                    errors++;
                    $display("FAIL start_err cycle %0d: got %h want %h", c, obs4, e);
                end
            end
            start4 = (c == 0) || (c == 7);
            @(negedge clk);
        end
        start4 = 1'b0;
        clear_to_idle4();
    endtask

    task automatic test_clear_abort();
        logic [11:0] e;
        for (int c = 0; c <= 33; c++) begin
            if (c > 0) begin
                if (c <= 10)      e = exp4(c);
                else if (c <= 12) e = 12'h000;
                else              e = exp4(c - 12);
                checks++;
                if (obs4 !== e) begin
                    errors++;
                    $display("FAIL clear_abort cycle %0d: got %h want %h", c, obs4, e);
                end
            end
            start4 = (c == 0) || (c == 12);
            clear4 = (c == 10);
            @(negedge clk);
        end
        start4 = 1'b0;
        clear4 = 1'b0;
        clear_to_idle4();
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        for (int c = 0; c <= 60; c++) begin
            if (c > 0) begin
                if (c <= 20)      e = exp4(c);
                else if (c <= 40) e = exp4(c - 20);
                else              e = exp4(c - 40);
                checks++;
                if (obs4 !== e) begin
                    errors++;
                    $display("FAIL back_to_back cycle %0d: got %h want %h", c, obs4, e);
                end
            end
            start4 = (c == 0) || (c == 20) || (c == 40);
            clear4 = (c == 20);
            @(negedge clk);
        end
        start4 = 1'b0;
        clear4 = 1'b0;
        clear_to_idle4();
    endtask

    task automatic test_size16();
        int nl = 0, nm = 0, na = 0, nb = 0, multi = 0;
        int done_first = -1, busy_first = -1, busy_last = -1;
        for (int c = 0; c <= 85; c++) begin
            if (c > 0) begin
                nl += int'(load_en16);
                nm += int'(mult_en16);
                na += int'(acc_en16);
                if (busy16) begin
                    nb++;
                    if (busy_first < 0) busy_first = c;
                    busy_last = c;
                end
                if (int'(load_en16) + int'(mult_en16) + int'(acc_en16) > 1) multi++;
                if (done16 && done_first < 0) done_first = c;
            end
            start16 = (c == 0);
            @(negedge clk);
        end
        start16 = 1'b0;
        checks++; if (nl !== 16) begin errors++; $display("FAIL s16_load_cycles: got %0d want 16", nl); end
        checks++; if (nm !== 46) begin errors++; $display("FAIL s16_mult_cycles: got %0d want 46", nm); end
        checks++; if (na !== 16) begin errors++; $display("FAIL s16_acc_cycles: got %0d want 16", na); end
        checks++; if (done_first !== 79) begin errors++; $display("FAIL s16_done_cycle: got %0d want 79", done_first); end
        checks++; if (busy_first !== 1 || busy_last !== 78 || nb !== 78) begin
            errors++;
            $display("FAIL s16_busy: got first %0d last %0d count %0d want 1 78 78", busy_first, busy_last, nb);
        end
        checks++; if (multi !== 0) begin errors++; $display("FAIL s16_onehot: got %0d overlaps want 0", multi); end
        checks++; if (!done16) begin errors++; $display("FAIL s16_done_held: got %b want 1", done16); end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
                checks++;
                if (obs4 !== exp4(c)) begin
                    errors++;
                    $display("FAIL pre_reset cycle %0d: got %h want %h", c, obs4, exp4(c));
                end
            end
            start4 = (c == 0);
            if (c < 16) @(negedge clk);
        end
        start4 = 1'b0;
        // Mid-ACC, well away from any rising edge.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs4 !== 12'h000 || done16 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h done16 %b want 000 0", obs4, done16);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs4 !== 12'h000) begin
            errors++;
            $display("FAIL post_reset_idle: got %h want 000", obs4);
        end
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        checks++;
        if (obs4 !== exp4(1)) begin
            errors++;
            $display("FAIL post_reset_start: got %h want %h", obs4, exp4(1));
        end
    endtask

    initial begin
        test_reset();
        test_schedule4();
        test_start_err();
        test_clear_abort();
        test_back_to_back();
        test_size16();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
